// File: rtl/rv_mem_pkg.sv
// Shared definitions for the memory-stage load/store unit.
//   - funct3 encodings for byte/half/word loads and stores
//   - FSM state encoding (IDLE/BUSY/DONE)
//   - check_legal : funct3 legality for a load or a store
//   - check_align : natural-alignment check for the access size
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Unsigned variants only exist for loads.
  function automatic logic check_legal(input logic [2:0] f3, input logic is_store);
    case (f3)
      F3_B, F3_H, F3_W: check_legal = 1'b1;
      F3_BU, F3_HU:     check_legal = ~is_store;
      default:          check_legal = 1'b0;
    endcase
  endfunction

  // f3[1:0] encodes the access size for every legal funct3.
  function automatic logic check_align(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   check_align = 1'b1;
      2'b01:   check_align = ~off[0];
      2'b10:   check_align = (off == 2'b00);
      default: check_align = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Ports:
//   f3        in  3   funct3 of the access
//   off       in  2   byte offset within the word (addr[1:0])
//   wd        in  32  raw store data
//   rdata     in  32  raw read word from memory
//   be        out 4   byte enables
//   wdata     out 32  store data replicated across lanes
//   load_data out 32  load result shifted down and extended
module lsu_align
  import rv_mem_pkg::*;
(
  input  logic [2:0]  f3,
  input  logic [1:0]  off,
  input  logic [31:0] wd,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0]        shifted;
  logic signed [31:0] sext_b;
  logic signed [31:0] sext_h;

  always_comb begin
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    case (f3[1:0])
      2'b00:   wdata = {4{wd[7:0]}};
      2'b01:   wdata = {2{wd[15:0]}};
      default: wdata = wd;
    endcase
  end

  assign shifted = rdata >> {off, 3'b000};
  assign sext_b  = 32'($signed(shifted[7:0]));
  assign sext_h  = 32'($signed(shifted[15:0]));

  always_comb begin
    case (f3)
      F3_B:    load_data = sext_b;
      F3_H:    load_data = sext_h;
      F3_BU:   load_data = {24'd0, shifted[7:0]};
      F3_HU:   load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit.
// Turns the EX/MEM register outputs into a word-aligned data-memory request,
// runs the req/ack handshake with a timeout while stalling the pipeline, and
// returns the aligned/extended load result to the MEM/WB register.
// Ports:
//   clk, reset (sync, active-low)
//   InstrM, MemReadM, MemWriteM, ALUResultM, WriteDataM : access from EX/MEM
//   ReadDataM  : registered load result, valid in DONE
//   StallM     : hold upstream registers
//   MisalignM, IllegalM : combinational access flags (IDLE only)
//   BusErrM    : one-cycle pulse after a timeout
//   dmem_req/we/addr/be/wdata : registered request, stable through BUSY
//   dmem_ack, dmem_rdata      : memory completion and read word
module mem_stage_lsu
  import rv_mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = $clog2(TIMEOUT)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  InstrM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        IllegalM,
  output logic        BusErrM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  logic [1:0]      state;
  logic [TO_W-1:0] cnt;
  logic [2:0]      f3_p1;
  logic [1:0]      off_p1;

  logic        single_op;
  logic        legal;
  logic        aligned;
  logic        in_idle;
  logic        vld_p0;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;

  assign single_op = MemReadM ^ MemWriteM;
  assign legal     = check_legal(InstrM, MemWriteM);
  assign aligned   = check_align(InstrM, ALUResultM[1:0]);
  assign in_idle   = (state == IDLE);

  assign IllegalM  = in_idle & ((MemReadM & MemWriteM) | (single_op & ~legal));
  assign MisalignM = in_idle & single_op & legal & ~aligned;
  assign vld_p0    = in_idle & single_op & legal & aligned;
  assign StallM    = vld_p0 | (state == BUSY);

  // One aligner serves both phases: live inputs shape the request in IDLE,
  // the latched funct3/offset extract the returning word in BUSY.
  assign al_f3  = (state == BUSY) ? f3_p1  : InstrM;
  assign al_off = (state == BUSY) ? off_p1 : ALUResultM[1:0];

  lsu_align u_align (
    .f3        (al_f3),
    .off       (al_off),
    .wd        (WriteDataM),
    .rdata     (dmem_rdata),
    .be        (al_be),
    .wdata     (al_wdata),
    .load_data (al_load)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      f3_p1      <= '0;
      off_p1     <= '0;
      ReadDataM  <= '0;
      BusErrM    <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
    end else begin
      case (state)
        // IDLE -> BUSY: capture the request
        IDLE: begin
          BusErrM <= 1'b0;
          if (vld_p0) begin
            dmem_req   <= 1'b1;
            dmem_we    <= MemWriteM;
            dmem_addr  <= {ALUResultM[31:2], 2'b00};
            dmem_be    <= al_be;
            dmem_wdata <= al_wdata;
            f3_p1      <= InstrM;
            off_p1     <= ALUResultM[1:0];
            cnt        <= '0;
            state      <= BUSY;
          end
        end
        // BUSY: wait for ack; ack beats a coincident timeout
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (dmem_ack) begin
            if (!dmem_we) ReadDataM <= al_load;
            dmem_req <= 1'b0;
            state    <= DONE;
          end else if (cnt == TO_W'(TIMEOUT - 1)) begin
            BusErrM  <= 1'b1;
            dmem_req <= 1'b0;
            state    <= DONE;
          end
        end
        // DONE: pipeline advances; no new access this cycle
        DONE: begin
          BusErrM <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  InstrM = '0;
  logic        MemReadM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [31:0] ALUResultM = '0;
  logic [31:0] WriteDataM = '0;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        MisalignM;
  logic        IllegalM;
  logic        BusErrM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;

  int checks = 0;
  int fails  = 0;

  mem_stage_lsu dut (
    .clk        (clk),
    .reset      (reset),
    .InstrM     (InstrM),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .IllegalM   (IllegalM),
    .BusErrM    (BusErrM),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in;
    InstrM = '0; MemReadM = 1'b0; MemWriteM = 1'b0;
    ALUResultM = '0; WriteDataM = '0; dmem_ack = 1'b0;
  endtask

  // Drives one access and plays memory: ack in the BUSY cycle with index
  // wait_n (0-based), never if wait_n is out of range. Returns after the
  // DONE cycle has passed and the unit is back in IDLE.
  task automatic do_access(input logic [2:0] f3, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int wait_n, input logic [31:0] rdata,
                           output int stall_n, output int busy_n, output int berr_n,
                           output logic [3:0] be_c, output logic we_c,
                           output logic [31:0] addr_c, output logic [31:0] wdata_c,
                           output bit ok);
    bit done;
    done = 0; stall_n = 0; busy_n = 0; berr_n = 0;
    be_c = '0; we_c = 1'b0; addr_c = '0; wdata_c = '0;
    InstrM = f3; MemReadM = rd; MemWriteM = wr; ALUResultM = addr; WriteDataM = wd;
    #1;
    for (int i = 0; i < 60 && !done; i++) begin
      if (StallM) stall_n++;
      if (BusErrM) berr_n++;
      if (dmem_req) begin
        be_c = dmem_be; we_c = dmem_we; addr_c = dmem_addr; wdata_c = dmem_wdata;
        dmem_ack = (busy_n == wait_n);
        dmem_rdata = rdata;
        busy_n++;
      end else begin
        dmem_ack = 1'b0;
      end
      if (stall_n > 0 && !StallM) done = 1;
      tick;
    end
    if (BusErrM) berr_n++;
    ok = done;
    clear_in;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    clear_in;
    tick; tick;
    checks++; if (dmem_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b want 0", dmem_req); end
    checks++; if (ReadDataM !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", ReadDataM); end
    checks++; if (BusErrM !== 1'b0) begin fails++; $display("FAIL reset_buserr got %b want 0", BusErrM); end
    checks++; if (StallM !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", StallM); end
    checks++; if (dmem_be !== 4'h0 || dmem_addr !== 32'h0) begin fails++; $display("FAIL reset_bus be %h addr %h want 0", dmem_be, dmem_addr); end
    reset = 1'b1;
    tick;
  endtask

  task automatic test_lw;
    int s, b, e; logic [3:0] be; logic we; logic [31:0] a, w; bit ok;
    do_access(3'b010, 1, 0, 32'h100, 32'h0, 1, 32'hDEADBEEF, s, b, e, be, we, a, w, ok);
    checks++; if (!ok) begin fails++; $display("FAIL lw_done handshake did not complete"); end
    checks++; if (be !== 4'hF) begin fails++; $display("FAIL lw_be got %h want f", be); end
    checks++; if (a !== 32'h100 || we !== 1'b0) begin fails++; $display("FAIL lw_addr got %h we %b want 100 we 0", a, we); end
    checks++; if (s != 3) begin fails++; $display("FAIL lw_stall got %0d want 3", s); end
    checks++; if (b != 2) begin fails++; $display("FAIL lw_busy got %0d want 2", b); end
    checks++; if (ReadDataM !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_data got %h want deadbeef", ReadDataM); end
  endtask

  task automatic test_min_latency_and_sub_word;
    int s, b, e; logic [3:0] be; logic we; logic [31:0] a, w; bit ok;
    do_access(3'b000, 1, 0, 32'h103, 32'h0, 0, 32'h80123456, s, b, e, be, we, a, w, ok);
    checks++; if (be !== 4'b1000) begin fails++; $display("FAIL lb_be got %b want 1000", be); end
    checks++; if (a !== 32'h100) begin fails++; $display("FAIL lb_addr got %h want 100", a); end
    checks++; if (s != 2) begin fails++; $display("FAIL lb_stall got %0d want 2", s); end
    checks++; if (ReadDataM !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_data got %h want ffffff80", ReadDataM); end
    do_access(3'b100, 1, 0, 32'h103, 32'h0, 0, 32'h80123456, s, b, e, be, we, a, w, ok);
    checks++; if (ReadDataM !== 32'h00000080) begin fails++; $display("FAIL lbu_data got %h want 00000080", ReadDataM); end
    do_access(3'b001, 1, 0, 32'h102, 32'h0, 0, 32'h80010000, s, b, e, be, we, a, w, ok);
    checks++; if (be !== 4'b1100) begin fails++; $display("FAIL lh_be got %b want 1100", be); end
    checks++; if (ReadDataM !== 32'hFFFF8001) begin fails++; $display("FAIL lh_data got %h want ffff8001", ReadDataM); end
    do_access(3'b101, 1, 0, 32'h102, 32'h0, 0, 32'h80010000, s, b, e, be, we, a, w, ok);
    checks++; if (ReadDataM !== 32'h00008001) begin fails++; $display("FAIL lhu_data got %h want 00008001", ReadDataM); end
  endtask

  task automatic test_store;
    int s, b, e; logic [3:0] be; logic we; logic [31:0] a, w; bit ok;
    do_access(3'b001, 0, 1, 32'h202, 32'h1234ABCD, 0, 32'h55555555, s, b, e, be, we, a, w, ok);
    checks++; if (we !== 1'b1) begin fails++; $display("FAIL sh_we got %b want 1", we); end
    checks++; if (be !== 4'b1100) begin fails++; $display("FAIL sh_be got %b want 1100", be); end
    checks++; if (w !== 32'hABCDABCD) begin fails++; $display("FAIL sh_wdata got %h want abcdabcd", w); end
    checks++; if (a !== 32'h200) begin fails++; $display("FAIL sh_addr got %h want 200", a); end
    checks++; if (ReadDataM !== 32'h00008001) begin fails++; $display("FAIL sh_rdata got %h want 00008001", ReadDataM); end
    do_access(3'b000, 0, 1, 32'h301, 32'h000000A5, 0, 32'h0, s, b, e, be, we, a, w, ok);
    checks++; if (be !== 4'b0010 || w !== 32'hA5A5A5A5) begin fails++; $display("FAIL sb_lane be %b wdata %h want 0010 a5a5a5a5", be, w); end
  endtask

  task automatic test_flags;
    bit req_seen;
    req_seen = 0;
    InstrM = 3'b010; MemReadM = 1'b1; ALUResultM = 32'h101;
    #1;
    checks++; if (MisalignM !== 1'b1) begin fails++; $display("FAIL misalign_flag got %b want 1", MisalignM); end
    checks++; if (StallM !== 1'b0) begin fails++; $display("FAIL misalign_stall got %b want 0", StallM); end
    for (int i = 0; i < 4; i++) begin tick; if (dmem_req) req_seen = 1; end
    checks++; if (req_seen) begin fails++; $display("FAIL misalign_req got 1 want 0"); end
    InstrM = 3'b001; ALUResultM = 32'h103;
    #1;
    checks++; if (MisalignM !== 1'b1) begin fails++; $display("FAIL misalign_lh got %b want 1", MisalignM); end
    InstrM = 3'b011; ALUResultM = 32'h100;
    #1;
    checks++; if (IllegalM !== 1'b1 || MisalignM !== 1'b0) begin fails++; $display("FAIL illegal_f3 got ill %b mis %b want 1 0", IllegalM, MisalignM); end
    InstrM = 3'b100; MemReadM = 1'b0; MemWriteM = 1'b1;
    #1;
    checks++; if (IllegalM !== 1'b1 || StallM !== 1'b0) begin fails++; $display("FAIL illegal_sbu got ill %b stall %b want 1 0", IllegalM, StallM); end
    InstrM = 3'b010; MemReadM = 1'b1;
    #1;
    checks++; if (IllegalM !== 1'b1) begin fails++; $display("FAIL illegal_rw got %b want 1", IllegalM); end
    tick;
    checks++; if (dmem_req !== 1'b0) begin fails++; $display("FAIL illegal_req got %b want 0", dmem_req); end
    clear_in;
    tick;
  endtask

  task automatic test_timeout;
    int s, b, e; logic [3:0] be; logic we; logic [31:0] a, w; bit ok;
    do_access(3'b010, 0, 1, 32'h400, 32'h11223344, 99, 32'h0, s, b, e, be, we, a, w, ok);
    checks++; if (!ok) begin fails++; $display("FAIL to_done handshake did not complete"); end
    checks++; if (b != 16) begin fails++; $display("FAIL to_busy got %0d want 16", b); end
    checks++; if (e != 1) begin fails++; $display("FAIL to_buserr pulses got %0d want 1", e); end
    checks++; if (s != 17) begin fails++; $display("FAIL to_stall got %0d want 17", s); end
    do_access(3'b010, 1, 0, 32'h404, 32'h0, 15, 32'hCAFEF00D, s, b, e, be, we, a, w, ok);
    checks++; if (b != 16 || e != 0) begin fails++; $display("FAIL ack16 busy %0d buserr %0d want 16 0", b, e); end
    checks++; if (ReadDataM !== 32'hCAFEF00D) begin fails++; $display("FAIL ack16_data got %h want cafef00d", ReadDataM); end
  endtask

  task automatic test_stray_ack;
    dmem_rdata = 32'h12345678; dmem_ack = 1'b1;
    tick; tick;
    dmem_ack = 1'b0;
    #1;
    checks++; if (ReadDataM !== 32'hCAFEF00D || StallM !== 1'b0) begin fails++; $display("FAIL stray_ack data %h stall %b want cafef00d 0", ReadDataM, StallM); end
  endtask

  task automatic test_reset_mid_busy;
    InstrM = 3'b010; MemReadM = 1'b1; ALUResultM = 32'h500;
    tick;
    checks++; if (dmem_req !== 1'b1) begin fails++; $display("FAIL rst_busy1 req got %b want 1", dmem_req); end
    tick;
    reset = 1'b0; clear_in;
    tick;
    checks++; if (dmem_req !== 1'b0 || StallM !== 1'b0) begin fails++; $display("FAIL rst_mid req %b stall %b want 0 0", dmem_req, StallM); end
    checks++; if (ReadDataM !== 32'h0 || dmem_addr !== 32'h0 || dmem_be !== 4'h0) begin fails++; $display("FAIL rst_mid_out data %h addr %h be %h want 0", ReadDataM, dmem_addr, dmem_be); end
    reset = 1'b1;
    MemReadM = 1'b1; InstrM = 3'b010; ALUResultM = 32'h503;
    #1;
    checks++; if (MisalignM !== 1'b1) begin fails++; $display("FAIL rst_idle flags got %b want 1 (state not IDLE)", MisalignM); end
    clear_in;
    tick;
  endtask

  initial begin
    test_reset;
    test_lw;
    test_min_latency_and_sub_word;
    test_store;
    test_flags;
    test_timeout;
    test_stray_ack;
    test_reset_mid_busy;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
